// File: rtl/sa_wresp_router.sv
`default_nettype none
// ============================================================================
// Module   : sa_wresp_router
// Purpose  : Slave-arbiter B-channel return path. Routes slave write responses
//            to the issuing master in AW order and merges 4KB-split pairs.
// Options  : SA_BRESP_ID_CHECK_EN enables the sticky BID-vs-order check.
// Revision : 1.0 - initial release
// ============================================================================
module sa_wresp_router #(
    parameter int MST_AMT         = 3,
    parameter int OUTSTANDING_AMT = 8,
    parameter int MST_ID_W        = $clog2(MST_AMT),
    parameter int TRANS_MST_ID_W  = 5,
    parameter int TRANS_SLV_ID_W  = TRANS_MST_ID_W + MST_ID_W,
    parameter int TRANS_WR_RESP_W = 2
) (
    input  logic                                ACLK_i,
    input  logic                                ARESETn_i,
    input  logic [MST_ID_W-1:0]                 xADDR_mst_id_i,
    input  logic                                xADDR_crossing_flag_i,
    input  logic                                xADDR_fifo_order_wr_en_i,
    output logic                                order_full_o,
    input  logic [TRANS_SLV_ID_W-1:0]           s_BID_i,
    input  logic [TRANS_WR_RESP_W-1:0]          s_BRESP_i,
    input  logic                                s_BVALID_i,
    output logic                                s_BREADY_o,
    output logic [TRANS_MST_ID_W*MST_AMT-1:0]   dsp_BID_o,
    output logic [TRANS_WR_RESP_W*MST_AMT-1:0]  dsp_BRESP_o,
    output logic [MST_AMT-1:0]                  dsp_BVALID_o,
    input  logic [MST_AMT-1:0]                  dsp_BREADY_i,
    output logic                                id_mismatch_o
);

    localparam int C_PTR_W = $clog2(OUTSTANDING_AMT);
    localparam int C_CNT_W = C_PTR_W + 1;

    typedef enum logic [0:0] {
        ST_NORMAL = 1'b0,
        ST_SPLIT2 = 1'b1
    } state_t;

    // ------------------------------------------------------------------
    // Order FIFO
    // ------------------------------------------------------------------
    logic [MST_ID_W-1:0] fifo_mst_q   [OUTSTANDING_AMT];
    logic                fifo_cross_q [OUTSTANDING_AMT];
    logic [C_PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [C_PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [C_CNT_W-1:0]  count_q, count_d;

    logic                order_full;
    logic                order_empty;
    logic                push;
    logic                pop;
    logic [MST_ID_W-1:0] h_mst;
    logic                h_cross;

    assign order_full  = (count_q == C_CNT_W'(OUTSTANDING_AMT));
    assign order_empty = (count_q == '0);
    // A simultaneous pop frees a slot, so a push at full is still accepted.
    assign push        = xADDR_fifo_order_wr_en_i & (~order_full | pop);
    assign h_mst       = fifo_mst_q[rd_ptr_q];
    assign h_cross     = fifo_cross_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + C_PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + C_PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + C_CNT_W'(1);
            2'b01:   count_d = count_q - C_CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge ACLK_i) begin
        if (push) begin
            fifo_mst_q[wr_ptr_q]   <= xADDR_mst_id_i;
            fifo_cross_q[wr_ptr_q] <= xADDR_crossing_flag_i;
        end
    end

    // ------------------------------------------------------------------
    // Output stage and response FSM
    // ------------------------------------------------------------------
    state_t                     state_q, state_d;
    logic [TRANS_WR_RESP_W-1:0] hold_resp_q, hold_resp_d;
    logic                       out_valid_q, out_valid_d;
    logic [MST_ID_W-1:0]        out_mst_q, out_mst_d;
    logic [TRANS_MST_ID_W-1:0]  out_id_q, out_id_d;
    logic [TRANS_WR_RESP_W-1:0] out_resp_q, out_resp_d;

    logic                       mst_bready;
    logic                       out_free;
    logic                       s_hs;
    logic                       load;
    logic [TRANS_WR_RESP_W-1:0] load_resp;

    always_comb begin
        mst_bready = 1'b0;
        for (int i = 0; i < MST_AMT; i++) begin
            if (out_mst_q == MST_ID_W'(i)) begin
                mst_bready = dsp_BREADY_i[i];
            end
        end
    end

    assign out_free   = ~out_valid_q | mst_bready;
    // The first half of a split only lands in hold_resp, so it needs no output slot.
    assign s_BREADY_o = ~order_empty & (((state_q == ST_NORMAL) & h_cross) | out_free);
    assign s_hs       = s_BVALID_i & s_BREADY_o;

    always_comb begin
        state_d     = state_q;
        hold_resp_d = hold_resp_q;
        pop         = 1'b0;
        load        = 1'b0;
        load_resp   = s_BRESP_i;
        if (s_hs) begin
            case (state_q)
                ST_NORMAL: begin
                    if (h_cross) begin
                        hold_resp_d = s_BRESP_i;
                        state_d     = ST_SPLIT2;
                    end else begin
                        load = 1'b1;
                        pop  = 1'b1;
                    end
                end
                ST_SPLIT2: begin
                    // Worst response wins; the encoding is ordered by severity.
                    load_resp = (s_BRESP_i > hold_resp_q) ? s_BRESP_i : hold_resp_q;
                    load      = 1'b1;
                    pop       = 1'b1;
                    state_d   = ST_NORMAL;
                end
                default: state_d = ST_NORMAL;
            endcase
        end
    end

    always_comb begin
        out_valid_d = out_valid_q;
        out_mst_d   = out_mst_q;
        out_id_d    = out_id_q;
        out_resp_d  = out_resp_q;
        if (load) begin
            out_valid_d = 1'b1;
            out_mst_d   = h_mst;
            out_id_d    = s_BID_i[TRANS_MST_ID_W-1:0];
            out_resp_d  = load_resp;
        end else if (out_valid_q & mst_bready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge ACLK_i or negedge ARESETn_i) begin
        if (!ARESETn_i) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            state_q     <= ST_NORMAL;
            hold_resp_q <= '0;
            out_valid_q <= 1'b0;
            out_mst_q   <= '0;
            out_id_q    <= '0;
            out_resp_q  <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            state_q     <= state_d;
            hold_resp_q <= hold_resp_d;
            out_valid_q <= out_valid_d;
            out_mst_q   <= out_mst_d;
            out_id_q    <= out_id_d;
            out_resp_q  <= out_resp_d;
        end
    end

    // ------------------------------------------------------------------
    // Dispatcher outputs
    // ------------------------------------------------------------------
    assign order_full_o = order_full;
    assign dsp_BID_o    = {MST_AMT{out_id_q}};
    assign dsp_BRESP_o  = {MST_AMT{out_resp_q}};

    for (genvar g = 0; g < MST_AMT; g++) begin : g_dsp_valid
        assign dsp_BVALID_o[g] = out_valid_q & (out_mst_q == MST_ID_W'(g));
    end

    // ------------------------------------------------------------------
    // Optional BID routing check
    // ------------------------------------------------------------------
`ifdef SA_BRESP_ID_CHECK_EN
    logic id_mismatch_q, id_mismatch_d;

    always_comb begin
        id_mismatch_d = id_mismatch_q;
        if (s_hs && (s_BID_i[TRANS_SLV_ID_W-1-:MST_ID_W] != h_mst)) begin
            id_mismatch_d = 1'b1;
        end
    end

    always_ff @(posedge ACLK_i or negedge ARESETn_i) begin
        if (!ARESETn_i) begin
            id_mismatch_q <= 1'b0;
        end else begin
            id_mismatch_q <= id_mismatch_d;
        end
    end

    assign id_mismatch_o = id_mismatch_q;
`else
    logic unused_bid_msb;
    assign unused_bid_msb = &{1'b0, s_BID_i[TRANS_SLV_ID_W-1-:MST_ID_W]};
    assign id_mismatch_o  = 1'b0;
`endif

endmodule
`default_nettype wire
